// File: rtl/ghost_mover.sv
// Tile-grid sprite mover: accepts a one-tile target, validates it, then walks 1 pixel per STEP_DIV clocks.
// Optional wall rejection is enabled by defining GHOST_MOVER_WALL_CHECK_EN.

`ifndef WIDTH
`define WIDTH 560
`endif
`ifndef HEIGHT
`define HEIGHT 620
`endif
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 28
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 31
`endif
`ifndef DIR_UP
`define DIR_UP 2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module ghost_mover #(
    parameter int RESET_X  = 20,
    parameter int RESET_Y  = 160,
    parameter int TILE     = 20,
    parameter int STEP_DIV = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    req_valid,
    input  logic [$clog2(`WIDTH)-1:0]               req_x,
    input  logic [$clog2(`HEIGHT)-1:0]              req_y,
    input  logic [1:0]                              req_dir,
    output logic                                    req_ready,
    input  logic                                    freeze,
    input  logic [`TILE_ROW_NUM*`TILE_COL_NUM-1:0]  tilemap_walls,
    output logic [$clog2(`WIDTH)-1:0]               x,
    output logic [$clog2(`HEIGHT)-1:0]              y,
    output logic [1:0]                              direction,
    output logic                                    moving,
    output logic                                    arrived,
    output logic                                    blocked
);

    localparam int XW = $clog2(`WIDTH);
    localparam int YW = $clog2(`HEIGHT);
    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int NT = `TILE_ROW_NUM * `TILE_COL_NUM;
    localparam int IW = $clog2(NT);
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_MOVE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   tx_q, tx_d, x_q, x_d, nx_s;
    logic [YW-1:0]   ty_q, ty_d, y_q, y_d, ny_s;
    logic [1:0]      tdir_q, tdir_d, dir_q, dir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            arrived_q, arrived_d, blocked_q, blocked_d;
    logic [31:0]     x32_s, y32_s, tx32_s, ty32_s;
    logic            on_grid_s, in_range_s, same_s, h_ok_s, v_ok_s, wall_hit_s, legal_s;
    logic            step_s, at_target_s;

    // Target legality, evaluated against the latched request during CHECK
    always_comb begin
        x32_s      = 32'(x_q);
        y32_s      = 32'(y_q);
        tx32_s     = 32'(tx_q);
        ty32_s     = 32'(ty_q);
        on_grid_s  = ((tx32_s % 32'(TILE)) == 32'd0) && ((ty32_s % 32'(TILE)) == 32'd0);
        in_range_s = (tx32_s <= 32'(`WIDTH - TILE)) && (ty32_s <= 32'(`HEIGHT - TILE));
        same_s     = (tx32_s == x32_s) && (ty32_s == y32_s);
        h_ok_s     = (ty32_s == y32_s) &&
                     (((tx32_s == x32_s + 32'(TILE)) && (tdir_q == `DIR_RIGHT)) ||
                      ((x32_s >= 32'(TILE)) && (tx32_s == x32_s - 32'(TILE)) && (tdir_q == `DIR_LEFT)));
        v_ok_s     = (tx32_s == x32_s) &&
                     (((ty32_s == y32_s + 32'(TILE)) && (tdir_q == `DIR_DOWN)) ||
                      ((y32_s >= 32'(TILE)) && (ty32_s == y32_s - 32'(TILE)) && (tdir_q == `DIR_UP)));
        legal_s    = on_grid_s && in_range_s && (same_s || h_ok_s || v_ok_s) && !wall_hit_s;
    end

`ifdef GHOST_MOVER_WALL_CHECK_EN
    logic [IW-1:0] wall_idx_s;
    // Wall lookup; index is only meaningful when the target is in range
    always_comb begin
        wall_idx_s = IW'((ty32_s / 32'(TILE)) * 32'(`TILE_COL_NUM) + (tx32_s / 32'(TILE)));
        wall_hit_s = in_range_s && tilemap_walls[wall_idx_s];
    end
`else
    logic unused_walls_s;
    assign unused_walls_s = ^tilemap_walls;
    assign wall_hit_s     = 1'b0;
`endif

    // One-pixel step toward the target along the committed direction
    always_comb begin
        nx_s = x_q;
        ny_s = y_q;
        case (dir_q)
            `DIR_RIGHT: nx_s = x_q + XW'(1);
            `DIR_LEFT:  nx_s = x_q - XW'(1);
            `DIR_DOWN:  ny_s = y_q + YW'(1);
            `DIR_UP:    ny_s = y_q - YW'(1);
            default:    nx_s = x_q;
        endcase
        step_s      = (state_q == S_MOVE) && !freeze && (cnt_q == CNT_MAX);
        at_target_s = (nx_s == tx_q) && (ny_s == ty_q);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_CHECK;
                else           state_d = S_IDLE;
            end
            S_CHECK: begin
                if (legal_s && !same_s) state_d = S_MOVE;
                else                    state_d = S_IDLE;
            end
            S_MOVE: begin
                if (step_s && at_target_s) state_d = S_IDLE;
                else                       state_d = S_MOVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-decoded outputs; ready is withheld while reset is asserted
    always_comb begin
        req_ready = (state_q == S_IDLE) && !reset;
        moving    = (state_q == S_MOVE);
    end

    // Datapath next-state: target latch, position, direction, step counter, pulses
    always_comb begin
        tx_d      = tx_q;
        ty_d      = ty_q;
        tdir_d    = tdir_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        arrived_d = 1'b0;
        blocked_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tx_d   = req_x;
                    ty_d   = req_y;
                    tdir_d = req_dir;
                end else begin
                    tx_d   = tx_q;
                end
            end
            S_CHECK: begin
                if (!legal_s) begin
                    blocked_d = 1'b1;
                end else if (same_s) begin
                    arrived_d = 1'b1;
                end else begin
                    dir_d = tdir_q;
                    cnt_d = '0;
                end
            end
            S_MOVE: begin
                if (freeze) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    x_d       = nx_s;
                    y_d       = ny_s;
                    arrived_d = at_target_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q      <= XW'(RESET_X);
            ty_q      <= YW'(RESET_Y);
            tdir_q    <= `DIR_RIGHT;
            x_q       <= XW'(RESET_X);
            y_q       <= YW'(RESET_Y);
            dir_q     <= `DIR_RIGHT;
            cnt_q     <= '0;
            arrived_q <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            tdir_q    <= tdir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            arrived_q <= arrived_d;
            blocked_q <= blocked_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign direction = dir_q;
    assign arrived   = arrived_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover with STEP_DIV=2; wall expectations follow GHOST_MOVER_WALL_CHECK_EN.

`ifndef WIDTH
`define WIDTH 560
`endif
`ifndef HEIGHT
`define HEIGHT 620
`endif
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 28
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 31
`endif
`ifndef DIR_UP
`define DIR_UP 2'd0
`endif
`ifndef DIR_DOWN
`define DIR_DOWN 2'd1
`endif
`ifndef DIR_LEFT
`define DIR_LEFT 2'd2
`endif
`ifndef DIR_RIGHT
`define DIR_RIGHT 2'd3
`endif

module tb_ghost_mover;

    logic                                   clk = 1'b0;
    logic                                   reset;
    logic                                   req_valid;
    logic [$clog2(`WIDTH)-1:0]              req_x;
    logic [$clog2(`HEIGHT)-1:0]             req_y;
    logic [1:0]                             req_dir;
    logic                                   req_ready;
    logic                                   freeze;
    logic [`TILE_ROW_NUM*`TILE_COL_NUM-1:0] tilemap_walls;
    logic [$clog2(`WIDTH)-1:0]              x;
    logic [$clog2(`HEIGHT)-1:0]             y;
    logic [1:0]                             direction;
    logic                                   moving;
    logic                                   arrived;
    logic                                   blocked;

    int errors = 0;
    int checks = 0;

    ghost_mover #(.RESET_X(20), .RESET_Y(160), .TILE(20), .STEP_DIV(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_dir(req_dir), .req_ready(req_ready), .freeze(freeze), .tilemap_walls(tilemap_walls),
        .x(x), .y(y), .direction(direction), .moving(moving), .arrived(arrived), .blocked(blocked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer a request in IDLE, then return in the cycle after CHECK
    task automatic request(input int rx, input int ry, input logic [1:0] rd);
        chk("ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_x     = rx[$clog2(`WIDTH)-1:0];
        req_y     = ry[$clog2(`HEIGHT)-1:0];
        req_dir   = rd;
        tick();
        req_valid = 1'b0;
        chk("ready_in_check", req_ready, 0);
        tick();
    endtask

    // Follow a horizontal move; x advances one pixel per two unfrozen cycles
    task automatic run_move(input int x0, input int sgn, input int exp_cyc,
                            input int fz_at, input int fz_len);
        int k;
        int n;
        k = 0;
        n = 0;
        while (moving === 1'b1 && k < 200) begin
            chk("move_x", x, x0 + sgn * (n / 2));
            chk("move_no_pulse", {arrived, blocked}, 0);
            freeze    = (k >= fz_at) && (k < fz_at + fz_len);
            req_valid = (k == 5);
            req_x     = '0;
            req_y     = '0;
            req_dir   = `DIR_LEFT;
            if (!freeze) n++;
            tick();
            k++;
        end
        freeze    = 1'b0;
        req_valid = 1'b0;
        chk("move_cycles", k, exp_cyc);
        chk("arrived_pulse", arrived, 1);
        chk("arrived_not_blocked", blocked, 0);
        chk("final_x", x, x0 + sgn * 20);
        chk("final_y", y, 160);
        chk("moving_done", moving, 0);
        chk("ready_after_move", req_ready, 1);
        tick();
        chk("arrived_once", arrived, 0);
    endtask

    initial begin
        int guard;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_x         = '0;
        req_y         = '0;
        req_dir       = `DIR_UP;
        freeze        = 1'b0;
        tilemap_walls = '0;
        tick();
        tick();
        chk("rst_x", x, 20);
        chk("rst_y", y, 160);
        chk("rst_dir", direction, 32'(`DIR_RIGHT));
        chk("rst_flags", {moving, arrived, blocked}, 0);
        chk("rst_ready_low", req_ready, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_rst", req_ready, 1);

        request(20, 160, `DIR_RIGHT);
        chk("zero_arrived", arrived, 1);
        chk("zero_not_blocked", blocked, 0);
        chk("zero_x", x, 20);
        tick();
        chk("zero_pulse_end", arrived, 0);

        request(60, 160, `DIR_RIGHT);
        chk("two_tile_blocked", blocked, 1);
        chk("two_tile_no_arrive", {arrived, moving}, 0);
        chk("two_tile_x", x, 20);
        tick();
        chk("blocked_pulse_end", blocked, 0);

        request(20, 180, `DIR_UP);
        chk("dir_mismatch_blocked", blocked, 1);
        chk("dir_mismatch_y", y, 160);
        chk("dir_mismatch_dir", direction, 32'(`DIR_RIGHT));
        tick();

        request(30, 160, `DIR_RIGHT);
        chk("off_grid_blocked", blocked, 1);
        tick();

        tilemap_walls[8 * `TILE_COL_NUM + 2] = 1'b1;
        request(40, 160, `DIR_RIGHT);
`ifdef GHOST_MOVER_WALL_CHECK_EN
        chk("wall_blocked", blocked, 1);
        chk("wall_x", x, 20);
        tick();
        tilemap_walls = '0;
        request(40, 160, `DIR_RIGHT);
`endif
        chk("move_right_dir", direction, 32'(`DIR_RIGHT));
        run_move(20, 1, 40, 0, 0);

        request(60, 160, `DIR_RIGHT);
        run_move(40, 1, 50, 10, 10);

        request(40, 160, `DIR_LEFT);
        chk("move_left_dir", direction, 32'(`DIR_LEFT));
        run_move(60, -1, 40, 0, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst2_x", x, 20);
        chk("rst2_dir", direction, 32'(`DIR_RIGHT));
        request(40, 160, `DIR_RIGHT);
        guard = 0;
        while (x !== 30 && guard < 100) begin
            tick();
            guard++;
        end
        chk("reached_30", x, 30);
        reset = 1'b1;
        tick();
        chk("midrst_x", x, 20);
        chk("midrst_flags", {moving, arrived, blocked}, 0);
        reset = 1'b0;
        tick();
        chk("midrst_idle", req_ready, 1);
        chk("midrst_no_arrive", {arrived, blocked, moving}, 0);
        chk("midrst_x_hold", x, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
